instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Packs instruction fields (pfix, opcode, rs, rd, imm) into 32-bit instruction words and
//  writes them sequentially into instruction memory. Exact inverse of the field decode used in the core.
//  Sits between the program-load source (testbench or host loader) and the instruction memory write port.
//  Stops loading after a HLT word is written, or on address overflow.
// PARAMETERS
//  ADDR_W   8   instruction-memory word-address width
// PORTS
//  clk        in   1        system clock; all state updates on rising edge
//  rst        in   1        asynchronous, active-high reset
//  start      in   1        1-cycle pulse: begin a load at base_addr (honoured only in IDLE/DONE/ERROR)
//  base_addr  in   ADDR_W   first write address, sampled when start is honoured
//  in_valid   in   1        field bundle valid
//  in_ready   out  1        encoder can accept a bundle
//  in_pfix    in   2        prefix field     -> word[31:30]
//  in_opcode  in   6        opcode field     -> word[29:24]
//  in_rs      in   4        source reg       -> word[23:20]
//  in_rd      in   4        dest reg         -> word[19:16]
//  in_imm     in   16       immediate        -> word[15:0]
//  mem_we     out  1        write request, held until mem_ack
//  mem_addr   out  ADDR_W   write address
//  mem_wdata  out  32       packed instruction word
//  mem_ack    in   1        memory accepted the write this cycle (valid only while mem_we=1)
//  count      out  ADDR_W+1 words written since last start
//  done       out  1        HLT written; level, held until next start
//  overflow   out  1        address space exhausted before HLT; level, held until next start
// BEHAVIOUR
//  Reset (async, any state, including mid-write): state=IDLE; in_ready=0, mem_we=0, mem_addr=0,
//   mem_wdata=0, count=0, done=0, overflow=0. No partial write survives reset.
//  FSM states: IDLE, LOAD, WRITE, DONE, ERROR.
//   IDLE : in_ready=0. start -> LOAD; addr<=base_addr, count<=0.
//   LOAD : in_ready=1. Transfer on in_valid&in_ready: latch packed word into mem_wdata -> WRITE.
//   WRITE: in_ready=0, mem_we=1, mem_addr/mem_wdata stable until mem_ack.
//          mem_ack: count++; if latched opcode==HLT (6'b001011) -> DONE;
//          else if addr==all-ones -> ERROR; else addr++ -> LOAD.
//   DONE : done=1, in_ready=0. start -> LOAD (done cleared on same edge).
//   ERROR: overflow=1, in_ready=0. start -> LOAD (overflow cleared on same edge).
//  Latency: bundle accepted on edge N -> mem_we=1 from cycle N+1; minimum 2 cycles per word
//   (mem_ack tied high gives one word every 2 cycles).
//  Packing is pure concatenation, no field checks; pfix/opcode values other than HLT pass through.
//  HLT detection uses opcode only; pfix/rs/rd/imm of the HLT word are written unmodified.
//  start in LOAD or WRITE is ignored (no restart mid-load). in_valid outside LOAD is ignored
//   and the bundle is not consumed.
//  Address wrap never occurs: last address written, then ERROR unless that word was HLT (HLT wins -> DONE).
//  mem_ack while mem_we=0 is ignored.
// STRUCTURE
//  instr_pkg: field bit positions, field widths, opcode localparams (HLT=6'b001011), FSM state
//   encoding; shared with the decoder so both ends agree on layout.
//  Sub-module instr_pack: combinational {pfix,opcode,rs,rd,imm} -> 32-bit word; FSM, address and
//   count registers stay in instr_encoder.
// TESTING
//  1. rst mid-WRITE (mem_we=1, no ack) -> all outputs at reset values same cycle, state IDLE, no ack consumed.
//  2. start base=8'h10; bundle pfix=01,op=000001,rs=3,rd=5,imm=16'h1234, ack next cycle
//     -> mem_we@N+1, addr=8'h10, wdata=32'h41351234, count=1, back in LOAD.
//  3. Three bundles then HLT (op=001011, rest 0), mem_ack delayed 3 cycles each -> addrs 10..13,
//     last wdata=32'h0B000000, done=1, count=4, in_ready=0; further in_valid ignored.
//  4. start base=8'hFE, three non-HLT bundles -> writes at FE, FF, then overflow=1, count=2,
//     third bundle never accepted; base=8'hFF with HLT -> done=1, overflow=0.
//  5. start pulsed during WRITE -> ignored, address sequence unchanged; start in DONE -> count=0,
//     done=0, new load at new base.
//  6. in_valid held high in IDLE with mem_ack=1 -> in_ready=0, mem_we never asserted.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Instruction word layout, opcode constants and encoder FSM states.
// The decoder in the core imports the same package, so both ends agree on field placement.
package instr_encoder_pkg;

  localparam int INSTR_W  = 32;

  localparam int PFIX_W   = 2;
  localparam int OPCODE_W = 6;
  localparam int REG_W    = 4;
  localparam int IMM_W    = 16;

  localparam int PFIX_LSB   = 30;
  localparam int OPCODE_LSB = 24;
  localparam int RS_LSB     = 20;
  localparam int RD_LSB     = 16;
  localparam int IMM_LSB    = 0;

  localparam logic [OPCODE_W-1:0] OP_HLT = 6'b001011;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } enc_state_t;

  // Pulls the opcode back out of a packed word.
  function automatic logic [OPCODE_W-1:0] word_opcode(input logic [INSTR_W-1:0] w);
    return w[OPCODE_LSB +: OPCODE_W];
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Program-load bundle, memory write port and status signals of the encoder.
// slave = encoder side; master = loader/memory side.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  import instr_encoder_pkg::*;

  logic                  start;
  logic [ADDR_W-1:0]     base_addr;
  logic                  in_valid;
  logic                  in_ready;
  logic [PFIX_W-1:0]     in_pfix;
  logic [OPCODE_W-1:0]   in_opcode;
  logic [REG_W-1:0]      in_rs;
  logic [REG_W-1:0]      in_rd;
  logic [IMM_W-1:0]      in_imm;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [INSTR_W-1:0]    mem_wdata;
  logic                  mem_ack;
  logic [ADDR_W:0]       count;
  logic                  done;
  logic                  overflow;

  modport slave (
    input  start, base_addr, in_valid, in_pfix, in_opcode, in_rs, in_rd, in_imm, mem_ack,
    output in_ready, mem_we, mem_addr, mem_wdata, count, done, overflow
  );

  modport master (
    output start, base_addr, in_valid, in_pfix, in_opcode, in_rs, in_rd, in_imm, mem_ack,
    input  in_ready, mem_we, mem_addr, mem_wdata, count, done, overflow
  );

endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational field packer: pure concatenation, no field checks.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [PFIX_W-1:0]   pfix,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [REG_W-1:0]    rs,
  input  logic [REG_W-1:0]    rd,
  input  logic [IMM_W-1:0]    imm,
  output logic [INSTR_W-1:0]  word
);

  // Place each field at its package-defined bit position.
  always_comb begin
    word = '0;
    word[PFIX_LSB   +: PFIX_W]   = pfix;
    word[OPCODE_LSB +: OPCODE_W] = opcode;
    word[RS_LSB     +: REG_W]    = rs;
    word[RD_LSB     +: REG_W]    = rd;
    word[IMM_LSB    +: IMM_W]    = imm;
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs field bundles and writes them to sequential
// instruction-memory addresses until a HLT word lands or the address space runs out.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  instr_encoder_if.slave  bus
);

  enc_state_t          state;
  logic [ADDR_W-1:0]   addr;
  logic [INSTR_W-1:0]  wdata;
  logic [ADDR_W:0]     count;
  logic                ready;
  logic                we;
  logic                done;
  logic                overflow;
  logic [INSTR_W-1:0]  packed_word;

  instr_pack u_pack (
    .pfix   (bus.in_pfix),
    .opcode (bus.in_opcode),
    .rs     (bus.in_rs),
    .rd     (bus.in_rd),
    .imm    (bus.in_imm),
    .word   (packed_word)
  );

  // Load FSM; every output is a register so the memory port sees clean levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      addr     <= '0;
      wdata    <= '0;
      count    <= '0;
      ready    <= 1'b0;
      we       <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.start) begin
            state    <= S_LOAD;
            addr     <= bus.base_addr;
            count    <= '0;
            ready    <= 1'b1;
            done     <= 1'b0;
            overflow <= 1'b0;
          end
        end
        S_LOAD: begin
          if (bus.in_valid) begin
            wdata <= packed_word;
            we    <= 1'b1;
            ready <= 1'b0;
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          // Address and data stay frozen until the memory acknowledges.
          if (bus.mem_ack) begin
            we    <= 1'b0;
            count <= count + (ADDR_W+1)'(1);
            if (word_opcode(wdata) == OP_HLT) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (&addr) begin
              // Never wrap: the top address was just written, stop here.
              state    <= S_ERROR;
              overflow <= 1'b1;
            end else begin
              addr  <= addr + ADDR_W'(1);
              ready <= 1'b1;
              state <= S_LOAD;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b0;
          we    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = ready;
  assign bus.mem_we    = we;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign bus.count     = count;
  assign bus.done      = done;
  assign bus.overflow  = overflow;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a vector table for the main load sequence
// plus hand-written sequences for reset, overflow and restart corners.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  instr_encoder_if #(.ADDR_W(8)) bus ();

  instr_encoder #(.ADDR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  pfix;
    logic [5:0]  op;
    logic [3:0]  rs;
    logic [3:0]  rd;
    logic [15:0] imm;
    int          dly;
    logic [7:0]  exp_addr;
    logic [31:0] exp_wdata;
    logic [8:0]  exp_cnt;
    logic        exp_rdy;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] base);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.base_addr = base;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  // Offer one bundle in LOAD, check the write, ack after dly cycles, check the aftermath.
  // pulse_start drives a start pulse (to base 8'h80) while the write is pending.
  task automatic send(input logic [1:0] pfix, input logic [5:0] op, input logic [3:0] rs,
                      input logic [3:0] rd, input logic [15:0] imm, input int dly,
                      input logic [7:0] exp_addr, input logic [31:0] exp_wdata,
                      input logic [8:0] exp_cnt, input logic exp_rdy, input logic pulse_start);
    check("ready_before", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_pfix   = pfix;
    bus.in_opcode = op;
    bus.in_rs     = rs;
    bus.in_rd     = rd;
    bus.in_imm    = imm;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("we_next_cycle", 32'(bus.mem_we), 32'd1);
    check("ready_in_write", 32'(bus.in_ready), 32'd0);
    check("addr", 32'(bus.mem_addr), 32'(exp_addr));
    check("wdata", bus.mem_wdata, exp_wdata);
    for (int i = 0; i < dly; i++) begin
      bus.start     = pulse_start && (i == 0);
      bus.base_addr = 8'h80;
      @(negedge clk);
      bus.start = 1'b0;
    end
    if (dly > 0) begin
      check("we_held", 32'(bus.mem_we), 32'd1);
      check("addr_held", 32'(bus.mem_addr), 32'(exp_addr));
      check("wdata_held", bus.mem_wdata, exp_wdata);
    end
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("we_dropped", 32'(bus.mem_we), 32'd0);
    check("count", 32'(bus.count), 32'(exp_cnt));
    check("ready_after", 32'(bus.in_ready), 32'(exp_rdy));
  endtask

  initial begin
    bus.start = 0; bus.base_addr = 0; bus.in_valid = 0; bus.mem_ack = 0;
    bus.in_pfix = 0; bus.in_opcode = 0; bus.in_rs = 0; bus.in_rd = 0; bus.in_imm = 0;

    // main sequence: three words then HLT at 8'h10.., first ack immediate, rest delayed 3
    vecs[0] = '{2'b01, 6'b000001, 4'h3, 4'h5, 16'h1234, 0, 8'h10, 32'h41351234, 9'd1, 1'b1};
    vecs[1] = '{2'b11, 6'b111111, 4'hF, 4'hF, 16'hFFFF, 3, 8'h11, 32'hFFFFFFFF, 9'd2, 1'b1};
    vecs[2] = '{2'b10, 6'b101010, 4'hA, 4'h5, 16'h5A5A, 3, 8'h12, 32'hAAA55A5A, 9'd3, 1'b1};
    vecs[3] = '{2'b00, 6'b001011, 4'h0, 4'h0, 16'h0000, 3, 8'h13, 32'h0B000000, 9'd4, 1'b0};

    // reset values
    rst = 1'b1;
    #12;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(bus.in_ready), 0);
    check("rst_we", 32'(bus.mem_we), 0);
    check("rst_count", 32'(bus.count), 0);
    check("rst_done", 32'(bus.done), 0);

    // reset mid-write: outputs clear immediately, pending write discarded
    do_start(8'h10);
    bus.in_valid = 1'b1; bus.in_pfix = 2'b01; bus.in_opcode = 6'b000001;
    bus.in_rs = 4'h3; bus.in_rd = 4'h5; bus.in_imm = 16'h1234;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("pre_rst_we", 32'(bus.mem_we), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_we", 32'(bus.mem_we), 0);
    check("arst_addr", 32'(bus.mem_addr), 0);
    check("arst_wdata", bus.mem_wdata, 0);
    check("arst_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    rst = 1'b0;

    // in_valid and mem_ack in IDLE: nothing happens
    bus.in_valid = 1'b1;
    bus.mem_ack  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_we", 32'(bus.mem_we), 0);
      check("idle_ready", 32'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    bus.mem_ack  = 1'b0;
    check("idle_count", 32'(bus.count), 0);

    // table-driven main load
    do_start(8'h10);
    for (int i = 0; i < 4; i++)
      send(vecs[i].pfix, vecs[i].op, vecs[i].rs, vecs[i].rd, vecs[i].imm, vecs[i].dly,
           vecs[i].exp_addr, vecs[i].exp_wdata, vecs[i].exp_cnt, vecs[i].exp_rdy, 1'b0);
    check("hlt_done", 32'(bus.done), 1);
    check("hlt_ovf", 32'(bus.overflow), 0);

    // bundles after HLT are ignored
    bus.in_valid = 1'b1; bus.mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0; bus.mem_ack = 1'b0;
    check("post_hlt_we", 32'(bus.mem_we), 0);
    check("post_hlt_count", 32'(bus.count), 4);
    check("post_hlt_done", 32'(bus.done), 1);

    // restart from DONE; start mid-write is ignored
    do_start(8'h20);
    check("restart_count", 32'(bus.count), 0);
    check("restart_done", 32'(bus.done), 0);
    send(2'b00, 6'b000010, 4'h1, 4'h2, 16'h0003, 1, 8'h20, 32'h02120003, 9'd1, 1'b1, 1'b0);
    send(2'b11, 6'b111111, 4'hF, 4'hF, 16'hFFFF, 3, 8'h21, 32'hFFFFFFFF, 9'd2, 1'b1, 1'b1);
    send(2'b11, 6'b001011, 4'h7, 4'h9, 16'hBEEF, 0, 8'h22, 32'hCB79BEEF, 9'd3, 1'b0, 1'b0);
    check("hlt_fields_done", 32'(bus.done), 1);

    // overflow at the top of the address space
    do_start(8'hFE);
    send(2'b11, 6'b111111, 4'hF, 4'hF, 16'hFFFF, 0, 8'hFE, 32'hFFFFFFFF, 9'd1, 1'b1, 1'b0);
    send(2'b10, 6'b101010, 4'hA, 4'h5, 16'h5A5A, 2, 8'hFF, 32'hAAA55A5A, 9'd2, 1'b0, 1'b0);
    check("ovf_flag", 32'(bus.overflow), 1);
    check("ovf_done", 32'(bus.done), 0);
    bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    check("ovf_no_accept_we", 32'(bus.mem_we), 0);
    check("ovf_count", 32'(bus.count), 2);

    // HLT on the last address wins over overflow
    do_start(8'hFF);
    check("ovf_cleared", 32'(bus.overflow), 0);
    send(2'b00, 6'b001011, 4'h0, 4'h0, 16'h0000, 0, 8'hFF, 32'h0B000000, 9'd1, 1'b0, 1'b0);
    check("top_hlt_done", 32'(bus.done), 1);
    check("top_hlt_ovf", 32'(bus.overflow), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
